// File: rtl/modmul_interleaved_if.sv
// Handshake and operand bus for the bit-serial interleaved modular multiplier.
interface modmul_interleaved_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] n;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] r;
    logic             err;

    modport master (
        output start, a, b, n,
        input  busy, done, r, err
    );

    modport slave (
        input  start, a, b, n,
        output busy, done, r, err
    );
endinterface

// File: rtl/modmul_interleaved.sv
// Bit-serial interleaved modular multiplier r = (a * b) mod n, MSB first, one bit per cycle.
// Optional operand range check enabled by defining MODMUL_RANGE_CHECK_EN.
module modmul_interleaved #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    modmul_interleaved_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, n_q, n_d;
    logic [WIDTH+1:0] acc_q, acc_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             err_q, err_d;
    logic             busy_q, done_q;

    logic [WIDTH+1:0] t, n_ext, n2_ext, acc_next;
    logic             ge_n, ge_2n;

    // acc < n keeps t below 3n, so one subtraction of n or 2n always suffices.
    always_comb begin
        t        = {acc_q[WIDTH:0], 1'b0} + (a_q[cnt_q] ? {2'b00, b_q} : '0);
        n_ext    = {2'b00, n_q};
        n2_ext   = {1'b0, n_q, 1'b0};
        ge_2n    = (t >= n2_ext);
        ge_n     = (t >= n_ext);
        acc_next = ge_2n ? (t - n2_ext) : (ge_n ? (t - n_ext) : t);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        n_d     = n_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    n_d     = bus.n;
                    acc_d   = '0;
                    cnt_d   = CntW'(WIDTH - 1);
                    state_d = StRun;
`ifdef MODMUL_RANGE_CHECK_EN
                    if (bus.n == '0 || bus.a >= bus.n || bus.b >= bus.n) begin
                        r_d     = '0;
                        err_d   = 1'b1;
                        state_d = StDone;
                    end
`endif
                end
            end
            StRun: begin
                acc_d = acc_next;
                if (cnt_q == '0) begin
                    r_d     = acc_next[WIDTH-1:0];
                    err_d   = 1'b0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            n_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            r_q     <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            n_q     <= n_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            err_q   <= err_d;
            busy_q  <= (state_d == StRun);
            done_q  <= (state_d == StDone);
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.r    = r_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_modmul_interleaved.sv
// Directed bench for modmul_interleaved at WIDTH 6, 8 and 16, plus a 16-bit operand sweep.
module tb_modmul_interleaved;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    modmul_interleaved_if #(.WIDTH(6))  if6 ();
    modmul_interleaved_if #(.WIDTH(8))  if8 ();
    modmul_interleaved_if #(.WIDTH(16)) if16 ();

    modmul_interleaved #(.WIDTH(6))  u_dut6  (.clk(clk), .reset(reset), .bus(if6));
    modmul_interleaved #(.WIDTH(8))  u_dut8  (.clk(clk), .reset(reset), .bus(if8));
    modmul_interleaved #(.WIDTH(16)) u_dut16 (.clk(clk), .reset(reset), .bus(if16));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_in(input int w, input logic st, input logic [15:0] a, b, n);
        case (w)
            6: begin
                if6.start = st; if6.a = a[5:0]; if6.b = b[5:0]; if6.n = n[5:0];
            end
            8: begin
                if8.start = st; if8.a = a[7:0]; if8.b = b[7:0]; if8.n = n[7:0];
            end
            default: begin
                if16.start = st; if16.a = a; if16.b = b; if16.n = n;
            end
        endcase
    endtask

    // {busy, done, err, r zero-extended to 16 bits}
    function automatic logic [18:0] obs(input int w);
        case (w)
            6:       obs = {if6.busy, if6.done, if6.err, 10'd0, if6.r};
            8:       obs = {if8.busy, if8.done, if8.err, 8'd0, if8.r};
            default: obs = {if16.busy, if16.done, if16.err, if16.r};
        endcase
    endfunction

    // Called just after a rising edge with the DUT idle; returns one cycle after done.
    task automatic expect_op(input string tag, input int w, input logic [15:0] a, b, n,
                             input logic [15:0] exp_r, input logic exp_err,
                             input int exp_lat, input bit chk_r);
        logic [18:0] o;
        int          lat;
        int          nbusy;
        set_in(w, 1'b1, a, b, n);
        @(posedge clk); #1;
        set_in(w, 1'b0, ~a, ~b, ~n);
        lat   = 1;
        nbusy = 0;
        o     = obs(w);
        while (!o[17] && lat < 40) begin
            if (o[18]) nbusy++;
            @(posedge clk); #1;
            lat++;
            o = obs(w);
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_busy_cycles"}, nbusy, exp_lat - 1);
        if (chk_r) check({tag, "_r"}, {16'd0, o[15:0]}, {16'd0, exp_r});
        check({tag, "_err"}, {31'd0, o[16]}, {31'd0, exp_err});
        check({tag, "_busy_with_done"}, {31'd0, o[18]}, 0);
        @(posedge clk); #1;
        o = obs(w);
        check({tag, "_done_pulse"}, {31'd0, o[17]}, 0);
    endtask

    initial begin
        logic [18:0] o;
        logic [7:0]  a8, b8;
        logic [15:0] a16, b16, n16;
        int unsigned q_r[$];
        int          q_c[$];
        int          next_acc;
        int          dones;

        checks = 0;
        errors = 0;
        reset  = 1'b1;
        set_in(6, 1'b0, 0, 0, 0);
        set_in(8, 1'b0, 0, 0, 0);
        set_in(16, 1'b0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_w6", {13'd0, obs(6)}, 0);
        check("reset_w8", {13'd0, obs(8)}, 0);
        check("reset_w16", {13'd0, obs(16)}, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 5*7 mod 11 = 35 - 33 = 2
        expect_op("w6_basic", 6, 5, 7, 11, 2, 1'b0, 7, 1'b1);
        // 30000 - 119*251 = 131
        expect_op("w8_basic", 8, 200, 150, 251, 131, 1'b0, 9, 1'b1);
        // 254 = -1 mod 255, so 254*254 = 1
        expect_op("w8_max_mod", 8, 254, 254, 255, 1, 1'b0, 9, 1'b1);

`ifdef MODMUL_RANGE_CHECK_EN
        expect_op("rc_a_ge_n", 6, 12, 3, 11, 0, 1'b1, 1, 1'b1);
        expect_op("rc_n_zero", 6, 5, 7, 0, 0, 1'b1, 1, 1'b1);
`else
        expect_op("oor_no_hang", 6, 12, 3, 11, 0, 1'b0, 7, 1'b0);
`endif
        expect_op("w6_after_oor", 6, 5, 7, 11, 2, 1'b0, 7, 1'b1);

        // start held every cycle: accepts only at cycles 0, 10, 20
        next_acc = 0;
        dones    = 0;
        for (int c = 0; c < 30; c++) begin
            o = obs(8);
            if (o[17]) begin
                check("stress_busy_with_done", {31'd0, o[18]}, 0);
                if (q_c.size() > 0) begin
                    check("stress_done_cycle", c, q_c[0] + 9);
                    check("stress_r", {24'd0, o[7:0]}, q_r[0]);
                    void'(q_c.pop_front());
                    void'(q_r.pop_front());
                end else begin
                    check("stress_extra_done", {31'd0, o[17]}, 0);
                end
                dones++;
            end
            a8 = 8'((c * 13 + 5) % 251);
            b8 = 8'((c * 29 + 1) % 251);
            if (c == next_acc) begin
                q_r.push_back((32'(a8) * 32'(b8)) % 32'd251);
                q_c.push_back(c);
                next_acc += 10;
            end
            set_in(8, 1'b1, {8'd0, a8}, {8'd0, b8}, 16'd251);
            @(posedge clk); #1;
        end
        set_in(8, 1'b0, 0, 0, 0);
        check("stress_done_count", dones, 3);
        repeat (12) @(posedge clk);
        #1;

        // leave a nonzero r, then reset in the 4th RUN cycle
        expect_op("w8_pre_reset", 8, 254, 254, 255, 1, 1'b0, 9, 1'b1);
        set_in(8, 1'b1, 200, 150, 251);
        @(posedge clk); #1;
        set_in(8, 1'b0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_reset_state", {13'd0, obs(8)}, 0);
        repeat (2) @(posedge clk);
        #1;
        check("post_reset_idle", {13'd0, obs(8)}, 0);
        // 3*4 = 12 mod 7 = 5
        expect_op("after_reset", 8, 3, 4, 7, 5, 1'b0, 9, 1'b1);

        // 65534 = -1 mod 65535
        expect_op("w16_max_mod", 16, 65534, 65534, 65535, 1, 1'b0, 17, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            n16 = 16'($urandom_range(65535, 1));
            a16 = 16'($urandom % 32'(n16));
            b16 = 16'($urandom % 32'(n16));
            expect_op("sweep", 16, a16, b16, n16,
                      16'((32'(a16) * 32'(b16)) % 32'(n16)), 1'b0, 17, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
